// File: rtl/tx_code_group_gen.sv
// PCS transmit code-group generator feeding an 8B/10B encoder; turns the GMII txd/tx_en stream into octet + K flag + running disparity.
// Latency: one register; the input presented in cycle N selects the code-group shown in cycle N+1.
// Backpressure: none; one code-group is emitted every cycle. Frame start may drop one preamble octet to keep /S/ on an even slot.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   txd, tx_en      GMII transmit octet and enable
//   tx_code_group   encoder output for the current octet/tx_is_k/tx_disparity (combinational feedback)
//   octet, tx_is_k  registered octet and K flag to the encoder
//   tx_disparity    running disparity, 0 = RD-, 1 = RD+
//   tx_even         1 while the current code-group sits in an even slot
//   cg_err          sticky flag: encoder returned an illegal code-group
//   frame_count     16-bit count of /T/ code-groups sent, present only when TXCG_FRAME_CNT_EN is defined
module tx_code_group_gen #(
  parameter int OCTET_WIDTH = 8,
  parameter int CG_WIDTH    = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OCTET_WIDTH-1:0] txd,
  input  logic                   tx_en,
  input  logic [CG_WIDTH-1:0]    tx_code_group,
  output logic [OCTET_WIDTH-1:0] octet,
  output logic                   tx_is_k,
  output logic                   tx_disparity,
  output logic                   tx_even,
  output logic                   cg_err
`ifdef TXCG_FRAME_CNT_EN
  ,
  output logic [15:0]            frame_count
`endif
);

  localparam int ONES_W = $clog2(CG_WIDTH + 1);

  localparam logic [OCTET_WIDTH-1:0] K28_5 = OCTET_WIDTH'(8'hBC);
  localparam logic [OCTET_WIDTH-1:0] K27_7 = OCTET_WIDTH'(8'hFB);
  localparam logic [OCTET_WIDTH-1:0] K29_7 = OCTET_WIDTH'(8'hFD);
  localparam logic [OCTET_WIDTH-1:0] K23_7 = OCTET_WIDTH'(8'hF7);
  localparam logic [OCTET_WIDTH-1:0] D5_6  = OCTET_WIDTH'(8'hC5);
  localparam logic [OCTET_WIDTH-1:0] D16_2 = OCTET_WIDTH'(8'h50);

  typedef enum logic [2:0] {
    IDLE_K,
    IDLE_D,
    SOP,
    DATA,
    EOP_T,
    EOP_R,
    EOP_R2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [OCTET_WIDTH-1:0] octet_nxt;
  logic                   is_k_nxt;
  logic [ONES_W-1:0]      ones;
  logic                   rd_nxt;
  logic                   err_set;

  // The state register always names the code-group currently on the outputs,
  // so octet/tx_is_k are loaded from the state being entered.
  always_comb begin
    state_nxt = state;
    octet_nxt = K28_5;
    is_k_nxt  = 1'b1;

    case (state)
      IDLE_K:    state_nxt = IDLE_D;
      IDLE_D:    state_nxt = tx_en ? SOP : IDLE_K;
      SOP, DATA: state_nxt = tx_en ? DATA : EOP_T;
      EOP_T:     state_nxt = EOP_R;
      // Current slot even means the next one is odd: pad with a second /R/.
      EOP_R:     state_nxt = tx_even ? EOP_R2 : IDLE_K;
      EOP_R2:    state_nxt = IDLE_K;
      default:   state_nxt = IDLE_K;
    endcase

    case (state_nxt)
      IDLE_K: octet_nxt = K28_5;
      IDLE_D: begin
        // tx_disparity here is the RD the K28.5 is encoded with; /I1/ pulls
        // a positive RD back to negative, /I2/ keeps a negative RD.
        octet_nxt = tx_disparity ? D5_6 : D16_2;
        is_k_nxt  = 1'b0;
      end
      SOP:  octet_nxt = K27_7;
      DATA: begin
        octet_nxt = txd;
        is_k_nxt  = 1'b0;
      end
      EOP_T:   octet_nxt = K29_7;
      default: octet_nxt = K23_7;
    endcase
  end

  always_comb begin
    ones = '0;
    for (int i = 0; i < CG_WIDTH; i++) begin
      ones = ones + ONES_W'(tx_code_group[i]);
    end
  end

  // Running disparity follows the code-group actually produced by the
  // encoder; anything that is not 4/5/6 ones (including all-zero, the
  // encoder's "unsupported" answer) is an error and leaves RD alone.
  always_comb begin
    rd_nxt  = tx_disparity;
    err_set = 1'b0;
    if (tx_code_group == '0) begin
      err_set = 1'b1;
    end else if (ones == ONES_W'(CG_WIDTH / 2 + 1)) begin
      rd_nxt = 1'b1;
    end else if (ones == ONES_W'(CG_WIDTH / 2 - 1)) begin
      rd_nxt = 1'b0;
    end else if (ones != ONES_W'(CG_WIDTH / 2)) begin
      err_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE_K;
      octet        <= K28_5;
      tx_is_k      <= 1'b1;
      tx_disparity <= 1'b0;
      tx_even      <= 1'b1;
      cg_err       <= 1'b0;
    end else begin
      state        <= state_nxt;
      octet        <= octet_nxt;
      tx_is_k      <= is_k_nxt;
      tx_disparity <= rd_nxt;
      tx_even      <= ~tx_even;
      cg_err       <= cg_err | err_set;
    end
  end

`ifdef TXCG_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= 16'd0;
    end else if (state == EOP_T) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule
